// File: rtl/slotmaker_pkg.sv
// Shared types and constants for the virtual slot controller
// configuration path.
package slotmaker_pkg;

    localparam int NUM_SLOTS = 8;
    localparam int SLOT_W    = 3;
    localparam int CARD_W    = 8;

    localparam logic [CARD_W-1:0] CARD_NONE = 8'd0;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        ACCESS,
        CAPTURE
    } slot_cfg_state_t;

    typedef enum logic {
        REQ_HOST,
        REQ_BUS
    } slot_cfg_req_t;

endpackage

// File: rtl/slot_cfg_sequencer.sv
// Owns the slot-table config port: default-card load after reset,
// then round-robin host/bus access with a registered result per requester.
import slotmaker_pkg::*;

module slot_cfg_sequencer #(
    parameter logic [63:0] DEFAULT_CARDS = 64'h05_00_00_02_00_00_03_00
) (
    input  logic              clk_logic,
    input  logic              reset,
    input  logic              init_start,
    output logic              init_busy,
    input  logic              host_req,
    input  logic              host_wr,
    input  logic [SLOT_W-1:0] host_slot,
    input  logic [CARD_W-1:0] host_card_i,
    output logic              host_ack,
    output logic [CARD_W-1:0] host_card_o,
    input  logic              bus_req,
    input  logic              bus_wr,
    input  logic [SLOT_W-1:0] bus_slot,
    input  logic [CARD_W-1:0] bus_card_i,
    output logic              bus_ack,
    output logic [CARD_W-1:0] bus_card_o,
    output logic [SLOT_W-1:0] cfg_slot,
    output logic              cfg_wr,
    output logic [CARD_W-1:0] cfg_card_i,
    input  logic [CARD_W-1:0] cfg_card_o
);

    slot_cfg_state_t   r_state, w_state;
    logic [SLOT_W-1:0] r_idx, w_idx;
    slot_cfg_req_t     r_pri, w_pri;
    slot_cfg_req_t     r_sel, w_sel;
    logic              r_pend, w_pend;
    logic              r_busy, w_busy;
    logic [SLOT_W-1:0] r_cfg_slot, w_cfg_slot;
    logic              r_cfg_wr, w_cfg_wr;
    logic [CARD_W-1:0] r_cfg_card, w_cfg_card;
    logic              r_host_ack, w_host_ack;
    logic              r_bus_ack, w_bus_ack;
    logic [CARD_W-1:0] r_host_card, w_host_card;
    logic [CARD_W-1:0] r_bus_card, w_bus_card;
    logic              w_host_go;

    always_ff @(posedge clk_logic or posedge reset) begin
        if (reset) begin
            r_state     <= INIT;
            r_idx       <= '0;
            r_pri       <= REQ_HOST;
            r_sel       <= REQ_HOST;
            r_pend      <= 1'b0;
            r_busy      <= 1'b1;
            r_cfg_slot  <= '0;
            r_cfg_wr    <= 1'b0;
            r_cfg_card  <= CARD_NONE;
            r_host_ack  <= 1'b0;
            r_bus_ack   <= 1'b0;
            r_host_card <= CARD_NONE;
            r_bus_card  <= CARD_NONE;
        end else begin
            r_state     <= w_state;
            r_idx       <= w_idx;
            r_pri       <= w_pri;
            r_sel       <= w_sel;
            r_pend      <= w_pend;
            r_busy      <= w_busy;
            r_cfg_slot  <= w_cfg_slot;
            r_cfg_wr    <= w_cfg_wr;
            r_cfg_card  <= w_cfg_card;
            r_host_ack  <= w_host_ack;
            r_bus_ack   <= w_bus_ack;
            r_host_card <= w_host_card;
            r_bus_card  <= w_bus_card;
        end
    end

    assign w_host_go = host_req && (!bus_req || r_pri == REQ_HOST);

    // cfg_* are registered, so IDLE loads them with the granted request's
    // fields; they then serve as the latched copy through ACCESS/CAPTURE.
    always_comb begin
        w_state     = r_state;
        w_idx       = r_idx;
        w_pri       = r_pri;
        w_sel       = r_sel;
        w_pend      = r_pend;
        w_cfg_slot  = r_cfg_slot;
        w_cfg_wr    = 1'b0;
        w_cfg_card  = r_cfg_card;
        w_host_ack  = 1'b0;
        w_bus_ack   = 1'b0;
        w_host_card = r_host_card;
        w_bus_card  = r_bus_card;
        unique case (r_state)
            INIT: begin
                w_cfg_wr   = 1'b1;
                w_cfg_slot = r_idx;
                w_cfg_card = DEFAULT_CARDS[{r_idx, 3'b000} +: CARD_W];
                w_idx      = r_idx + 1'b1;
                if (r_idx == SLOT_W'(NUM_SLOTS - 1)) begin
                    w_state = IDLE;
                end
            end
            IDLE: begin
                if (init_start || r_pend) begin
                    w_state = INIT;
                    w_idx   = '0;
                    w_pend  = 1'b0;
                end else if (host_req || bus_req) begin
                    w_state    = ACCESS;
                    w_sel      = w_host_go ? REQ_HOST : REQ_BUS;
                    w_pri      = w_host_go ? REQ_BUS : REQ_HOST;
                    w_cfg_slot = w_host_go ? host_slot : bus_slot;
                    w_cfg_wr   = w_host_go ? host_wr : bus_wr;
                    w_cfg_card = w_host_go ? host_card_i : bus_card_i;
                end
            end
            ACCESS: begin
                w_state = CAPTURE;
                w_pend  = r_pend | init_start;
            end
            CAPTURE: begin
                w_state = IDLE;
                w_pend  = r_pend | init_start;
                if (r_sel == REQ_HOST) begin
                    w_host_ack  = 1'b1;
                    w_host_card = cfg_card_o;
                end else begin
                    w_bus_ack  = 1'b1;
                    w_bus_card = cfg_card_o;
                end
            end
        endcase
        // Busy also covers the cycle that shows the last default write.
        w_busy = (w_state == INIT) || (r_state == INIT);
    end

    assign init_busy   = r_busy;
    assign host_ack    = r_host_ack;
    assign host_card_o = r_host_card;
    assign bus_ack     = r_bus_ack;
    assign bus_card_o  = r_bus_card;
    assign cfg_slot    = r_cfg_slot;
    assign cfg_wr      = r_cfg_wr;
    assign cfg_card_i  = r_cfg_card;

endmodule

// File: tb/tb_slot_cfg_sequencer.sv
// Directed + random bench for slot_cfg_sequencer with a behavioural
// slot table and a transaction-level reference of its contents.
module tb_slot_cfg_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       init_start = 1'b0;
    logic       init_busy;
    logic       host_req = 1'b0, host_wr = 1'b0;
    logic [2:0] host_slot = '0;
    logic [7:0] host_card_i = '0;
    logic       host_ack;
    logic [7:0] host_card_o;
    logic       bus_req = 1'b0, bus_wr = 1'b0;
    logic [2:0] bus_slot = '0;
    logic [7:0] bus_card_i = '0;
    logic       bus_ack;
    logic [7:0] bus_card_o;
    logic [2:0] cfg_slot;
    logic       cfg_wr;
    logic [7:0] cfg_card_i;
    logic [7:0] cfg_card_o;

    logic [7:0] table_mem [8];
    logic [7:0] ref_tbl [8];
    logic [7:0] defaults [8] = '{8'h00, 8'h03, 8'h00, 8'h00,
                                 8'h02, 8'h00, 8'h00, 8'h05};
    bit         ref_pri_bus;
    int         n_chk = 0;
    int         n_err = 0;
    int         dual = 0;

    slot_cfg_sequencer dut (
        .clk_logic  (clk),
        .reset      (reset),
        .init_start (init_start),
        .init_busy  (init_busy),
        .host_req   (host_req),
        .host_wr    (host_wr),
        .host_slot  (host_slot),
        .host_card_i(host_card_i),
        .host_ack   (host_ack),
        .host_card_o(host_card_o),
        .bus_req    (bus_req),
        .bus_wr     (bus_wr),
        .bus_slot   (bus_slot),
        .bus_card_i (bus_card_i),
        .bus_ack    (bus_ack),
        .bus_card_o (bus_card_o),
        .cfg_slot   (cfg_slot),
        .cfg_wr     (cfg_wr),
        .cfg_card_i (cfg_card_i),
        .cfg_card_o (cfg_card_o)
    );

    always #5 clk = ~clk;

    // Slot table: registered read, echoes write data.
    always @(posedge clk) begin
        if (cfg_wr) begin
            table_mem[cfg_slot] <= cfg_card_i;
            cfg_card_o          <= cfg_card_i;
        end else begin
            cfg_card_o <= table_mem[cfg_slot];
        end
    end

    always @(negedge clk) begin
        if (host_ack && bus_ack) dual++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ref_reload();
        for (int i = 0; i < 8; i++) ref_tbl[i] = defaults[i];
    endtask

    task automatic reset_vals();
        chk("rst_busy", 32'(init_busy), 1);
        chk("rst_cfg_wr", 32'(cfg_wr), 0);
        chk("rst_cfg_slot", 32'(cfg_slot), 0);
        chk("rst_cfg_card", 32'(cfg_card_i), 0);
        chk("rst_acks", 32'({host_ack, bus_ack}), 0);
        chk("rst_host_card", 32'(host_card_o), 0);
        chk("rst_bus_card", 32'(bus_card_o), 0);
    endtask

    // Called at the negedge where reset was just released.
    task automatic init_check(input string tag);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c <= 8) begin
                chk({tag, "_wr"}, 32'(cfg_wr), 1);
                chk({tag, "_slot"}, 32'(cfg_slot), 32'(c - 1));
                chk({tag, "_card"}, 32'(cfg_card_i), 32'(defaults[c-1]));
                chk({tag, "_busy"}, 32'(init_busy), 1);
            end else begin
                chk({tag, "_busy_end"}, 32'(init_busy), 0);
                chk({tag, "_wr_end"}, 32'(cfg_wr), 0);
            end
        end
        ref_reload();
        ref_pri_bus = 1'b0;
    endtask

    task automatic do_txn(input bit is_bus, input bit wr,
                          input logic [2:0] slot, input logic [7:0] card,
                          output logic [7:0] got, output int lat);
        if (is_bus) begin
            bus_wr = wr; bus_slot = slot; bus_card_i = card; bus_req = 1'b1;
        end else begin
            host_wr = wr; host_slot = slot; host_card_i = card; host_req = 1'b1;
        end
        got = 'x;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                // Fields must already be latched by now.
                if (is_bus) begin
                    bus_wr = ~wr; bus_slot = 3'($urandom);
                    bus_card_i = 8'($urandom);
                end else begin
                    host_wr = ~wr; host_slot = 3'($urandom);
                    host_card_i = 8'($urandom);
                end
            end
            if (is_bus ? bus_ack : host_ack) begin
                got = is_bus ? bus_card_o : host_card_o;
                break;
            end
        end
        if (is_bus) bus_req = 1'b0;
        else host_req = 1'b0;
    endtask

    task automatic txn_chk(input string tag, input bit is_bus, input bit wr,
                           input logic [2:0] slot, input logic [7:0] card);
        logic [7:0] got;
        logic [7:0] exp;
        int         lat;
        exp = wr ? card : ref_tbl[slot];
        if (wr) ref_tbl[slot] = card;
        do_txn(is_bus, wr, slot, card, got, lat);
        ref_pri_bus = !is_bus;
        chk({tag, "_lat"}, 32'(lat), 3);
        chk({tag, "_card"}, 32'(got), 32'(exp));
    endtask

    initial begin
        bit         order_exp [$];
        bit         order_got [$];
        int         ack_cyc [$];
        int         hleft, bleft, hn, bn;
        bit         p;
        logic [7:0] got;
        int         lat;

        // 1: reset values and default load
        repeat (3) @(negedge clk);
        reset_vals();
        reset = 1'b0;
        init_check("init1");

        // 2: host write then bus read of the same slot
        txn_chk("t2_hwr", 1'b0, 1'b1, 3'd4, 8'h07);
        txn_chk("t2_brd", 1'b1, 1'b0, 3'd4, 8'h00);

        // 3: simultaneous held requests, two transactions each
        hleft = 2; bleft = 2; p = ref_pri_bus;
        while (hleft + bleft > 0) begin
            if (hleft > 0 && bleft > 0) begin
                order_exp.push_back(p);
                if (p) bleft--; else hleft--;
                p = !p;
            end else if (hleft > 0) begin
                order_exp.push_back(1'b0); hleft--; p = 1'b1;
            end else begin
                order_exp.push_back(1'b1); bleft--; p = 1'b0;
            end
        end
        host_wr = 1'b1; host_slot = 3'd2; host_card_i = 8'h11; host_req = 1'b1;
        bus_wr = 1'b0; bus_slot = 3'd2; bus_card_i = 8'h00; bus_req = 1'b1;
        ref_tbl[2] = 8'h11;
        hn = 0; bn = 0;
        for (int c = 1; c <= 40 && (hn < 2 || bn < 2); c++) begin
            @(negedge clk);
            if (host_ack) begin
                order_got.push_back(1'b0); ack_cyc.push_back(c);
                chk("t3_hcard", 32'(host_card_o), 32'(ref_tbl[2]));
                if (++hn == 2) host_req = 1'b0;
            end
            if (bus_ack) begin
                order_got.push_back(1'b1); ack_cyc.push_back(c);
                chk("t3_bcard", 32'(bus_card_o), 32'(ref_tbl[2]));
                if (++bn == 2) bus_req = 1'b0;
            end
        end
        host_req = 1'b0; bus_req = 1'b0;
        ref_pri_bus = p;
        chk("t3_count", 32'(order_got.size()), 4);
        for (int i = 0; i < 4 && i < order_got.size(); i++) begin
            chk("t3_order", 32'(order_got[i]), 32'(order_exp[i]));
            chk("t3_cycle", 32'(ack_cyc[i]), 32'(3 * (i + 1)));
        end

        // random single-requester traffic against the table reference
        for (int i = 0; i < 30; i++) begin
            txn_chk("rnd", 1'($urandom), 1'($urandom), 3'($urandom),
                    8'($urandom));
        end

        // 5: init_start during ACCESS of a host write
        host_wr = 1'b1; host_slot = 3'd1; host_card_i = 8'hAA; host_req = 1'b1;
        @(negedge clk);
        init_start = 1'b1;
        @(negedge clk);
        init_start = 1'b0;
        chk("t5_noack", 32'(host_ack), 0);
        @(negedge clk);
        chk("t5_ack", 32'(host_ack), 1);
        chk("t5_card", 32'(host_card_o), 32'h0AA);
        host_req = 1'b0;
        @(negedge clk);
        chk("t5_busy", 32'(init_busy), 1);
        lat = 0;
        while (init_busy && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("t5_busy_drop", 32'(init_busy), 0);
        ref_reload();
        ref_pri_bus = 1'b0;
        txn_chk("t5_rd1", 1'b0, 1'b0, 3'd1, 8'h00);

        // 6: reset in CAPTURE aborts the transaction
        host_wr = 1'b0; host_slot = 3'd4; host_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        reset_vals();
        @(negedge clk);
        chk("t6_noack", 32'({host_ack, bus_ack}), 0);
        host_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        init_check("init6");
        txn_chk("t6_rd4", 1'b0, 1'b0, 3'd4, 8'h00);

        // 4: bus request held through INIT
        @(negedge clk);
        reset = 1'b1;
        bus_wr = 1'b0; bus_slot = 3'd7; bus_req = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        init_check("init4");
        @(negedge clk);
        chk("t4_early", 32'(bus_ack), 0);
        @(negedge clk);
        chk("t4_ack", 32'(bus_ack), 1);
        chk("t4_card", 32'(bus_card_o), 32'(ref_tbl[7]));
        bus_req = 1'b0;
        repeat (2) @(negedge clk);

        chk("dual_ack", 32'(dual), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
